// File: rtl/fifo_rd_arbiter_pkg.sv
// rtl/fifo_rd_arbiter_pkg.sv - shared types, widths and round-robin pick for the FIFO read arbiter
package fifo_rd_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam int MAX_REQ     = 16;
  localparam int NUM_REQ_DEF = 4;
  localparam int TIMEOUT_DEF = 16;
  localparam int PTRW        = $clog2(NUM_REQ_DEF);
  localparam int STALLW      = (TIMEOUT_DEF > 0) ? $clog2(TIMEOUT_DEF + 1) : 1;

  // One-hot grant for the first set bit of req searching upward from last+1 (mod n).
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                 input logic [3:0]         last,
                                                 input int                 n);
    logic [MAX_REQ-1:0] g;
    int                 idx;
    g = '0;
    for (int i = MAX_REQ; i >= 1; i--) begin
      idx = (int'(last) + i) % n;
      if (i <= n && req[idx[3:0]]) g = MAX_REQ'(1) << idx[3:0];
    end
    return g;
  endfunction

endpackage

// File: rtl/fifo_rd_arbiter_if.sv
// rtl/fifo_rd_arbiter_if.sv - consumer and FIFO read-port signals of the read arbiter
interface fifo_rd_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DSIZE   = 8,
  parameter int LENW    = 4
);
  logic [NUM_REQ-1:0]      req_i;
  logic [NUM_REQ*LENW-1:0] len_i;
  logic                    fifo_empty_i;
  logic [DSIZE-1:0]        fifo_rdata_i;
  logic                    fifo_ren_o;
  logic [NUM_REQ-1:0]      gnt_o;
  logic [DSIZE-1:0]        rdata_o;
  logic [NUM_REQ-1:0]      rvalid_o;
  logic [NUM_REQ-1:0]      done_o;
  logic                    abort_o;

  modport slave (
    input  req_i, len_i, fifo_empty_i, fifo_rdata_i,
    output fifo_ren_o, gnt_o, rdata_o, rvalid_o, done_o, abort_o
  );

  modport master (
    output req_i, len_i, fifo_empty_i, fifo_rdata_i,
    input  fifo_ren_o, gnt_o, rdata_o, rvalid_o, done_o, abort_o
  );
endinterface

// File: rtl/fifo_rd_arbiter_rr_arbiter.sv
// rtl/fifo_rd_arbiter_rr_arbiter.sv - combinational round-robin picker with registered last pointer
module rr_arbiter
  import fifo_rd_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int PW      = PTRW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PW-1:0]      idx
);

  logic [PW-1:0]      last;
  logic [MAX_REQ-1:0] pick;

  assign pick = rr_pick(MAX_REQ'(req), 4'(last), NUM_REQ);
  assign gnt  = pick[NUM_REQ-1:0];

  always_comb begin
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (pick[i]) idx = PW'(i);
    end
  end

  // Reset to the top index so consumer 0 wins the first arbitration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last <= PW'(NUM_REQ - 1);
    else if (en) last <= idx;
  end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// rtl/fifo_rd_arbiter.sv - round-robin burst arbiter for the async FIFO read port with empty-timeout abort
module fifo_rd_arbiter
  import fifo_rd_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int DSIZE   = 8,
  parameter int LENW    = 4,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                rclk_i,
  input  logic                rrst_n_i,
  fifo_rd_arbiter_if.slave    bus
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [SW-1:0] STALL_MAX  = SW'(TIMEOUT);
  localparam logic [SW-1:0] STALL_LAST = SW'(TIMEOUT - 1);

  state_t             state, state_nx;
  logic [LENW-1:0]    cnt, cnt_nx;
  logic [SW-1:0]      stall, stall_nx;
  logic [NUM_REQ-1:0] gnt, gnt_nx;
  logic [NUM_REQ-1:0] rvalid, rvalid_nx;
  logic [NUM_REQ-1:0] done, done_nx;
  logic               abort, abort_nx;
  logic [DSIZE-1:0]   rdata, rdata_nx;
  logic               ren;
  logic               arb_en;
  logic [NUM_REQ-1:0] arb_gnt;
  logic [PW-1:0]      arb_idx;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PW      (PW)
  ) u_rr (
    .clk   (rclk_i),
    .rst_n (rrst_n_i),
    .req   (bus.req_i),
    .en    (arb_en),
    .gnt   (arb_gnt),
    .idx   (arb_idx)
  );

  always_ff @(posedge rclk_i or negedge rrst_n_i) begin
    if (!rrst_n_i) begin
      state  <= IDLE;
      cnt    <= '0;
      stall  <= '0;
      gnt    <= '0;
      rvalid <= '0;
      done   <= '0;
      abort  <= 1'b0;
      rdata  <= '0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      stall  <= stall_nx;
      gnt    <= gnt_nx;
      rvalid <= rvalid_nx;
      done   <= done_nx;
      abort  <= abort_nx;
      rdata  <= rdata_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    stall_nx  = stall;
    gnt_nx    = gnt;
    rdata_nx  = rdata;
    rvalid_nx = '0;
    done_nx   = '0;
    abort_nx  = 1'b0;
    ren       = 1'b0;
    arb_en    = 1'b0;
    case (state)
      IDLE: begin
        if (|bus.req_i) begin
          arb_en   = 1'b1;
          gnt_nx   = arb_gnt;
          cnt_nx   = bus.len_i[int'(arb_idx)*LENW +: LENW];
          stall_nx = '0;
          state_nx = BURST;
        end
      end
      BURST: begin
        ren = (cnt != '0) && !bus.fifo_empty_i;
        if (cnt == '0) begin
          state_nx = IDLE;
          gnt_nx   = '0;
          done_nx  = gnt;
        end else if (ren) begin
          cnt_nx    = cnt - LENW'(1);
          stall_nx  = '0;
          rdata_nx  = bus.fifo_rdata_i;
          rvalid_nx = gnt;
          if (cnt == LENW'(1)) begin
            state_nx = IDLE;
            gnt_nx   = '0;
            done_nx  = gnt;
          end
        end else begin
          // Only an empty FIFO can hold off a non-zero burst, so this is a stall cycle.
          if (stall != STALL_MAX) stall_nx = stall + SW'(1);
          if (TIMEOUT != 0 && stall == STALL_LAST) begin
            state_nx = IDLE;
            gnt_nx   = '0;
            done_nx  = gnt;
            abort_nx = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.fifo_ren_o = ren;
  assign bus.gnt_o      = gnt;
  assign bus.rvalid_o   = rvalid;
  assign bus.done_o     = done;
  assign bus.abort_o    = abort;
  assign bus.rdata_o    = rdata;

endmodule
